// File: rtl/vga_pkg.sv
// Shared defaults and types for the windowed VGA frame buffer.
package vga_pkg;

   localparam int unsigned SCREEN_WIDTH_DEF  = 640;
   localparam int unsigned SCREEN_HEIGHT_DEF = 480;
   localparam int unsigned X_W               = 10;
   localparam int unsigned Y_W               = 9;

   typedef enum logic {
      WRITING,
      FULL
   } wr_state_t;

endpackage

// File: rtl/vga_fb_ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-first, no reset.
module vga_fb_ram #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/vga_window_frame_buffer.sv
// Double-buffered frame store serving a centred window to the VGA raster, with a border
// colour outside it. Bank swap waits for vertical blank so a displayed frame never tears.
module vga_window_frame_buffer
   import vga_pkg::*;
#(
   parameter int unsigned FRAME_WIDTH   = 256,
   parameter int unsigned FRAME_HEIGHT  = 256,
   parameter int unsigned PIXEL_WIDTH   = 8,
   parameter int unsigned SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
   parameter int unsigned SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
   parameter int unsigned DOUBLE_BUFFER = 1,
   parameter logic [PIXEL_WIDTH-1:0] BORDER_COLOUR = '0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [PIXEL_WIDTH-1:0] wr_data,
   input  logic                   wr_sof,
   output logic                   wr_frame_done,
   input  logic [X_W-1:0]         x_position_vga,
   input  logic [Y_W-1:0]         y_position_vga,
   input  logic                   display_enable,
   input  logic                   frame_start_vga,
   output logic [PIXEL_WIDTH-1:0] vga_data_out,
   output logic                   vga_in_window,
   output logic                   active_bank
);

   localparam int unsigned LEFT  = (SCREEN_WIDTH - FRAME_WIDTH) / 2;
   localparam int unsigned TOP   = (SCREEN_HEIGHT - FRAME_HEIGHT) / 2;
   localparam int unsigned DEPTH = FRAME_WIDTH * FRAME_HEIGHT;
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned BAW   = (DOUBLE_BUFFER != 0) ? AW + 1 : AW;

   if (FRAME_WIDTH > SCREEN_WIDTH || FRAME_HEIGHT > SCREEN_HEIGHT) begin : g_bad_geometry
      $error("vga_window_frame_buffer: frame window larger than screen");
   end

   wr_state_t         state;
   logic [AW-1:0]     wr_addr;
   logic              accept;
   logic [BAW-1:0]    ram_waddr;
   logic [AW-1:0]     pix_index;
   logic              hit;
   logic              hit_s1, de_s1, hit_s2, de_s2;
   logic [BAW-1:0]    rd_addr;
   logic [PIXEL_WIDTH-1:0] ram_q;

   assign wr_ready = (DOUBLE_BUFFER == 0) || (state == WRITING);
   assign accept   = wr_valid && wr_ready;

   // A start-of-frame pixel always lands at address 0 regardless of the running pointer.
   always_comb begin
      ram_waddr = '0;
      if (DOUBLE_BUFFER != 0) begin
         ram_waddr = BAW'({~active_bank, (wr_sof ? AW'(0) : wr_addr)});
      end else begin
         ram_waddr = BAW'(wr_sof ? AW'(0) : wr_addr);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= WRITING;
         wr_addr       <= '0;
         active_bank   <= 1'b0;
         wr_frame_done <= 1'b0;
      end else begin
         wr_frame_done <= 1'b0;
         if (accept) begin
            if (wr_sof) begin
               wr_addr <= AW'(1);
            end else if (wr_addr == AW'(DEPTH - 1)) begin
               wr_addr       <= '0;
               wr_frame_done <= 1'b1;
               if (DOUBLE_BUFFER != 0) begin
                  state <= FULL;
               end
            end else begin
               wr_addr <= wr_addr + AW'(1);
            end
         end else if (state == FULL && frame_start_vga) begin
            state       <= WRITING;
            active_bank <= ~active_bank;
         end
      end
   end

   always_comb begin
      hit = display_enable
         && (32'(x_position_vga) >= LEFT) && (32'(x_position_vga) < LEFT + FRAME_WIDTH)
         && (32'(y_position_vga) >= TOP)  && (32'(y_position_vga) < TOP + FRAME_HEIGHT);
      pix_index = AW'((32'(x_position_vga) - LEFT)
                    + (32'(y_position_vga) - TOP) * FRAME_WIDTH);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hit_s1  <= 1'b0;
         de_s1   <= 1'b0;
         hit_s2  <= 1'b0;
         de_s2   <= 1'b0;
         rd_addr <= '0;
      end else begin
         hit_s1  <= hit;
         de_s1   <= display_enable;
         hit_s2  <= hit_s1;
         de_s2   <= de_s1;
         rd_addr <= (DOUBLE_BUFFER != 0) ? BAW'({active_bank, pix_index}) : BAW'(pix_index);
      end
   end

   vga_fb_ram #(
      .DATA_W (PIXEL_WIDTH),
      .ADDR_W (BAW)
   ) u_ram (
      .clk   (clk),
      .we    (accept),
      .waddr (ram_waddr),
      .wdata (wr_data),
      .raddr (rd_addr),
      .rdata (ram_q)
   );

   assign vga_data_out  = hit_s2 ? ram_q : (de_s2 ? BORDER_COLOUR : '0);
   assign vga_in_window = hit_s2;

endmodule

// File: tb/tb_vga_window_frame_buffer.sv
// Directed bench: 4x2 window on an 8x4 screen, one double-buffered and one single-bank instance.
module tb_vga_window_frame_buffer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       wr_valid = 1'b0, wr_sof = 1'b0, frame_start = 1'b0, de = 1'b0;
   logic [7:0] wr_data = '0;
   logic [9:0] x = '0;
   logic [8:0] y = '0;
   logic       wr_ready, done, win, bank;
   logic [7:0] vga;

   logic       s_wr_valid = 1'b0, s_wr_sof = 1'b0;
   logic [7:0] s_wr_data = '0;
   logic       s_wr_ready, s_done, s_win, s_bank;
   logic [7:0] s_vga;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   vga_window_frame_buffer #(
      .FRAME_WIDTH (4), .FRAME_HEIGHT (2), .PIXEL_WIDTH (8),
      .SCREEN_WIDTH (8), .SCREEN_HEIGHT (4), .DOUBLE_BUFFER (1), .BORDER_COLOUR (8'hAA)
   ) dut (
      .clk (clk), .reset_n (reset_n),
      .wr_valid (wr_valid), .wr_ready (wr_ready), .wr_data (wr_data), .wr_sof (wr_sof),
      .wr_frame_done (done),
      .x_position_vga (x), .y_position_vga (y), .display_enable (de),
      .frame_start_vga (frame_start),
      .vga_data_out (vga), .vga_in_window (win), .active_bank (bank)
   );

   vga_window_frame_buffer #(
      .FRAME_WIDTH (4), .FRAME_HEIGHT (2), .PIXEL_WIDTH (8),
      .SCREEN_WIDTH (8), .SCREEN_HEIGHT (4), .DOUBLE_BUFFER (0), .BORDER_COLOUR (8'hAA)
   ) dut_single (
      .clk (clk), .reset_n (reset_n),
      .wr_valid (s_wr_valid), .wr_ready (s_wr_ready), .wr_data (s_wr_data), .wr_sof (s_wr_sof),
      .wr_frame_done (s_done),
      .x_position_vga (x), .y_position_vga (y), .display_enable (de),
      .frame_start_vga (frame_start),
      .vga_data_out (s_vga), .vga_in_window (s_win), .active_bank (s_bank)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic raster(input logic [9:0] xi, input logic [8:0] yi, input logic dei);
      x  = xi;
      y  = yi;
      de = dei;
      step();
      step();
   endtask

   task automatic wr(input logic [7:0] d, input logic sof);
      wr_valid = 1'b1;
      wr_data  = d;
      wr_sof   = sof;
      step();
      wr_valid = 1'b0;
      wr_sof   = 1'b0;
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int done_cnt;
      logic ready_low;

      // Reset, then async re-assert while the border colour is being driven
      x = 10'd1; y = 9'd1; de = 1'b1;
      step(); step();
      check("rst_vga", 32'(vga), 32'h00);
      check("rst_win", 32'(win), 32'h0);
      check("rst_ready", 32'(wr_ready), 32'h1);
      check("rst_bank", 32'(bank), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      reset_n = 1'b1;
      step(); step(); step();
      check("pre_rst_border", 32'(vga), 32'hAA);
      #1 reset_n = 1'b0;
      #1;
      check("async_rst_vga", 32'(vga), 32'h00);
      reset_n = 1'b1;
      step();
      check("post_rst_ready", 32'(wr_ready), 32'h1);
      check("post_rst_bank", 32'(bank), 32'h0);

      // Full frame into bank 1
      for (int i = 0; i < 8; i++) begin
         wr(8'h10 + 8'(i), i == 0);
         if (i < 7) check("frame1_no_done", 32'(done), 32'h0);
      end
      check("frame1_done", 32'(done), 32'h1);
      check("frame1_ready_low", 32'(wr_ready), 32'h0);
      wr_valid = 1'b1;
      wr_data  = 8'h99;
      step();
      check("held_done", 32'(done), 32'h0);
      check("held_ready", 32'(wr_ready), 32'h0);
      step();
      wr_valid = 1'b0;

      pulse_fs();
      check("swap1_bank", 32'(bank), 32'h1);
      check("swap1_ready", 32'(wr_ready), 32'h1);

      raster(10'd2, 9'd1, 1'b1);
      check("rd_2_1", 32'(vga), 32'h10);
      check("rd_2_1_win", 32'(win), 32'h1);
      raster(10'd5, 9'd2, 1'b1);
      check("rd_5_2", 32'(vga), 32'h17);
      raster(10'd1, 9'd1, 1'b1);
      check("rd_1_1", 32'(vga), 32'hAA);
      check("rd_1_1_win", 32'(win), 32'h0);
      raster(10'd6, 9'd1, 1'b1);
      check("rd_6_1_right_edge", 32'(vga), 32'hAA);
      raster(10'd2, 9'd3, 1'b1);
      check("rd_2_3_bottom_edge", 32'(vga), 32'hAA);
      raster(10'd2, 9'd1, 1'b0);
      check("rd_blank", 32'(vga), 32'h00);
      check("rd_blank_win", 32'(win), 32'h0);

      // Restart mid-frame with wr_sof into bank 0
      done_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         wr(8'h30 + 8'(i), 1'b0);
         done_cnt += int'(done);
      end
      wr(8'h55, 1'b1);
      done_cnt += int'(done);
      check("sof_no_done", 32'(done_cnt), 32'd0);
      for (int i = 0; i < 7; i++) begin
         wr(8'h56 + 8'(i), 1'b0);
         done_cnt += int'(done);
      end
      check("sof_one_done", 32'(done_cnt), 32'd1);
      check("sof_ready_low", 32'(wr_ready), 32'h0);
      pulse_fs();
      check("swap2_bank", 32'(bank), 32'h0);
      raster(10'd2, 9'd1, 1'b1);
      check("sof_addr0", 32'(vga), 32'h55);
      raster(10'd4, 9'd1, 1'b1);
      check("sof_addr2", 32'(vga), 32'h57);
      raster(10'd5, 9'd2, 1'b1);
      check("sof_addr7", 32'(vga), 32'h5C);

      // Last pixel coincides with frame_start: no swap until the next one
      for (int i = 0; i < 7; i++) wr(8'h60 + 8'(i), i == 0);
      wr_valid    = 1'b1;
      wr_data     = 8'h67;
      frame_start = 1'b1;
      step();
      wr_valid    = 1'b0;
      frame_start = 1'b0;
      check("coinc_done", 32'(done), 32'h1);
      check("coinc_bank", 32'(bank), 32'h0);
      check("coinc_ready", 32'(wr_ready), 32'h0);
      step();
      check("coinc_bank_hold", 32'(bank), 32'h0);
      pulse_fs();
      check("coinc_swap_bank", 32'(bank), 32'h1);
      check("coinc_swap_ready", 32'(wr_ready), 32'h1);
      raster(10'd2, 9'd1, 1'b1);
      check("coinc_rd0", 32'(vga), 32'h60);
      raster(10'd5, 9'd2, 1'b1);
      check("coinc_rd7", 32'(vga), 32'h67);

      // Single-bank instance: wrap-around writes
      ready_low = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (!s_wr_ready) ready_low = 1'b1;
         s_wr_valid = 1'b1;
         s_wr_data  = 8'h20 + 8'(i);
         s_wr_sof   = (i == 0);
         step();
         if (!s_wr_ready) ready_low = 1'b1;
         if (i == 7) check("single_wrap_done", 32'(s_done), 32'h1);
         if (i == 8) check("single_after_wrap", 32'(s_done), 32'h0);
      end
      s_wr_valid = 1'b0;
      s_wr_sof   = 1'b0;
      check("single_ready_never_low", 32'(ready_low), 32'h0);
      check("single_bank", 32'(s_bank), 32'h0);
      raster(10'd2, 9'd1, 1'b1);
      check("single_rd0", 32'(s_vga), 32'h28);
      check("single_rd0_win", 32'(s_win), 32'h1);
      raster(10'd3, 9'd1, 1'b1);
      check("single_rd1", 32'(s_vga), 32'h21);
      raster(10'd1, 9'd2, 1'b1);
      check("single_border", 32'(s_vga), 32'hAA);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
